mem_port_arbiter: RTL and testbench

//  Shares one single-port instruction/data memory between the CPU fetch port (I) and the load/store port (D).

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_prio_pick.sv | 25 ++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//  - arb_state_e  : FSM states (IDLE / ISSUE / WAIT)
//  - OWN_I/OWN_D  : owner code of the transaction in flight
//  - STARVE_CNT_W : width of the starvation counter
package mem_port_arbiter_pkg;

    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_prio_pick.sv
// arb_prio_pick: combinational requester selection.
//  D wins unless I is also pending and D has already been granted
//  STARVE_LIMIT times in a row while I waited.
// Ports:
//  i_req, d_req  in   pending requests
//  starve_cnt    in   consecutive D grants taken while I was pending
//  pick_i/pick_d out  one-hot (or zero) selection
module arb_prio_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    i_req,
    input  logic                    d_req,
    input  logic [STARVE_CNT_W-1:0] starve_cnt,
    output logic                    pick_i,
    output logic                    pick_d
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

    assign pick_d = d_req && (!i_req || (starve_cnt < LIMIT_C));
    assign pick_i = i_req && !pick_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch port (I)
// and the load/store port (D). One transaction in flight at a time.
// Ports:
//  clk, rst                          clock, async active-low reset
//  i_req/i_addr -> i_gnt/i_rvalid/i_rdata            fetch side
//  d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata  load/store side
//  m_req/m_we/m_addr/m_wdata <- m_gnt/m_rvalid/m_rdata  memory side
//  busy  FSM not idle
//  err   sticky: memory response seen when none was expected
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              err
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_e              state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic                    i_rvalid_q, i_rvalid_d;
    logic                    d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]       i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]       d_rdata_q, d_rdata_d;
    logic                    err_q, err_d;

    logic pick_i, pick_d;

    arb_prio_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_q),
        .pick_i     (pick_i),
        .pick_d     (pick_d)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        // Any response outside WAIT (including one coinciding with m_gnt
        // in ISSUE) is unexpected and latched as an error.
        err_d      = err_q | (m_rvalid && (state_q != ST_WAIT));
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        m_req      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Grants are combinational, so mask them while reset is held
                // to keep every output quiet during reset.
                i_gnt = pick_i & rst;
                d_gnt = pick_d & rst;
                if (pick_i || pick_d) begin
                    state_d = ST_ISSUE;
                    owner_d = pick_d ? OWN_D : OWN_I;
                    we_d    = pick_d & d_we;
                    addr_d  = pick_d ? d_addr : i_addr;
                    wdata_d = pick_d ? d_wdata : '0;
                    if (pick_d && i_req)
                        starve_d = (starve_q >= LIMIT_C) ? LIMIT_C : starve_q + 1'b1;
                    else
                        starve_d = '0;
                end
            end
            ST_ISSUE: begin
                m_req = 1'b1;
                if (m_gnt) begin
                    if (we_q) begin
                        // Only D issues stores; completion needs no data phase.
                        state_d    = ST_IDLE;
                        d_rvalid_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (m_rvalid) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_D) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = m_rdata;
                    end else begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = m_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_I;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_q   <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            starve_q   <= starve_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign m_we     = we_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign busy     = (state_q != ST_IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (STARVE_LIMIT=2).
// Directed scenarios plus a randomized run checked against a
// transaction-level model of the arbiter and memory.
module tb_mem_port_arbiter;

    localparam int SL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, m_gnt, m_rvalid;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, busy, err;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [logic [31:0]];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        idle_inputs();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        logic [135:0] outs;
        rst = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
            i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            m_gnt = 1'($urandom); m_rvalid = 1'($urandom); m_rdata = $urandom;
            #1;
            outs = {i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, busy, err,
                    i_rdata, d_rdata, m_addr, m_wdata};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h want 0", outs);
            end
        end
        @(negedge clk);
        idle_inputs();
        rst = 1;
        #1;
        checks++;
        if ({busy, i_gnt, d_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: busy/i_gnt/d_gnt=%b want 000", {busy, i_gnt, d_gnt});
        end
        @(negedge clk); #1;
        checks++;
        if ({busy, i_gnt, d_gnt, m_req} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: busy/i_gnt/d_gnt/m_req=%b want 0000", {busy, i_gnt, d_gnt, m_req});
        end
    endtask

    task automatic test_single_load();
        @(negedge clk);
        i_req = 1; i_addr = 32'h0000_0040;
        #1;
        checks++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            errors++; $display("FAIL load_gnt: i_gnt/d_gnt=%b want 10", {i_gnt, d_gnt});
        end
        @(negedge clk);
        i_req = 0; i_addr = 32'hFFFF_FFFF; m_gnt = 1;
        #1;
        checks++;
        if ({m_req, m_we} !== 2'b10 || m_addr !== 32'h40) begin
            errors++; $display("FAIL load_issue: m_req=%b m_we=%b m_addr=%h want 1 0 40", m_req, m_we, m_addr);
        end
        @(negedge clk);
        m_gnt = 0; m_rvalid = 1; m_rdata = 32'h2008_0005;
        #1;
        checks++;
        if ({m_req, i_rvalid} !== 2'b00) begin
            errors++; $display("FAIL load_wait: m_req/i_rvalid=%b want 00", {m_req, i_rvalid});
        end
        @(negedge clk);
        m_rvalid = 0; m_rdata = 32'h0;
        #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h2008_0005 || d_rvalid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL load_rvalid: i_rvalid=%b i_rdata=%h d_rvalid=%b busy=%b want 1 20080005 0 0",
                               i_rvalid, i_rdata, d_rvalid, busy);
        end
        @(negedge clk); #1;
        checks++;
        if (i_rvalid !== 1'b0 || i_rdata !== 32'h2008_0005) begin
            errors++; $display("FAIL load_hold: i_rvalid=%b i_rdata=%h want 0 20080005", i_rvalid, i_rdata);
        end
    endtask

    task automatic test_store_stall();
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            errors++; $display("FAIL store_gnt: i_gnt/d_gnt=%b want 01", {i_gnt, d_gnt});
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            d_req = 0; d_we = 0; d_addr = $urandom; d_wdata = $urandom;
            m_gnt = (c == 4);
            #1;
            checks++;
            if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h100 ||
                m_wdata !== 32'hDEAD_BEEF || d_rvalid !== 1'b0) begin
                errors++; $display("FAIL store_stall_c%0d: m_req=%b m_we=%b m_addr=%h m_wdata=%h d_rvalid=%b want 1 1 100 deadbeef 0",
                                   c, m_req, m_we, m_addr, m_wdata, d_rvalid);
            end
        end
        @(negedge clk);
        m_gnt = 0;
        #1;
        checks++;
        if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || busy !== 1'b0 || m_req !== 1'b0) begin
            errors++; $display("FAIL store_done: d_rvalid=%b i_rvalid=%b busy=%b m_req=%b want 1 0 0 0",
                               d_rvalid, i_rvalid, busy, m_req);
        end
        @(negedge clk); #1;
        checks++;
        if (d_rvalid !== 1'b0) begin
            errors++; $display("FAIL store_pulse: d_rvalid=%b want 0", d_rvalid);
        end
    endtask

    task automatic test_contention();
        bit exp_d [6] = '{1, 1, 0, 1, 1, 0};
        int exp_c [6] = '{1, 2, 0, 1, 2, 0};
        do_reset();
        @(negedge clk);
        i_req = 1; i_addr = 32'h80; d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h1234_5678;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (d_gnt !== exp_d[k] || i_gnt !== !exp_d[k]) begin
                errors++; $display("FAIL contend_gnt%0d: i_gnt=%b d_gnt=%b want d=%b", k, i_gnt, d_gnt, exp_d[k]);
            end
            @(negedge clk);
            m_gnt = 1;
            #1;
            checks++;
            if (dut.starve_q !== 4'(exp_c[k])) begin
                errors++; $display("FAIL contend_cnt%0d: starve_cnt=%0d want %0d", k, dut.starve_q, exp_c[k]);
            end
            if (!exp_d[k]) begin
                @(negedge clk);
                m_gnt = 0; m_rvalid = 1; m_rdata = $urandom;
            end
            @(negedge clk);
            m_gnt = 0; m_rvalid = 0;
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h300;
        @(negedge clk);
        d_req = 0; m_gnt = 1;
        @(negedge clk);
        m_gnt = 0;
        #1;
        checks++;
        if (busy !== 1'b1 || m_req !== 1'b0) begin
            errors++; $display("FAIL rst_wait_pre: busy=%b m_req=%b want 1 0", busy, m_req);
        end
        rst = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || d_rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_wait_abort: busy=%b d_rvalid=%b want 0 0", busy, d_rvalid);
        end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        m_rvalid = 1; m_rdata = $urandom;
        @(negedge clk);
        m_rvalid = 0;
        #1;
        checks++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_wait_stray: i_rvalid=%b d_rvalid=%b err=%b busy=%b want 0 0 1 0",
                               i_rvalid, d_rvalid, err, busy);
        end
    endtask

    task automatic test_stray();
        do_reset();
        @(negedge clk);
        m_gnt = 1;
        #1;
        checks++;
        if (m_req !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL stray_gnt: m_req=%b busy=%b err=%b want 0 0 0", m_req, busy, err);
        end
        @(negedge clk);
        m_gnt = 0; m_rvalid = 1; m_rdata = 32'hA5A5_A5A5;
        #1;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin
            errors++; $display("FAIL stray_gnt_after: busy=%b err=%b rvalids=%b%b want 0 0 00", busy, err, i_rvalid, d_rvalid);
        end
        @(negedge clk);
        m_rvalid = 0;
        #1;
        checks++;
        if (err !== 1'b1 || i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || i_rdata !== 32'h0) begin
            errors++; $display("FAIL stray_rvalid: err=%b rvalids=%b%b i_rdata=%h want 1 00 0", err, i_rvalid, d_rvalid, i_rdata);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL stray_sticky: err=%b want 1", err);
        end
    endtask

    // Transaction-level model: one outstanding transaction described by
    // (owner, we, addr, wdata) and where it is in the memory handshake.
    task automatic test_random(input int ncyc);
        int          phase = 0;  // 0 none, 1 waiting for m_gnt, 2 waiting for data
        int          starve = 0;
        bit          ipend = 0, dpend = 0, own_d = 0, t_we = 0;
        bit          gi, gd, exp_irv = 0, exp_drv = 0;
        logic [31:0] t_addr = 0, t_wdata = 0, exp_ird = 0, exp_drd = 0;
        do_reset();
        mem.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (!ipend && $urandom_range(2) == 0) begin
                ipend = 1; i_addr = 32'($urandom_range(15)) << 2;
            end
            if (!dpend && $urandom_range(2) == 0) begin
                dpend = 1; d_addr = 32'($urandom_range(15)) << 2;
                d_we = 1'($urandom); d_wdata = $urandom;
            end
            i_req = ipend; d_req = dpend;
            m_gnt = (phase == 1) && ($urandom_range(1) == 1);
            m_rvalid = (phase == 2) && ($urandom_range(2) != 0);
            if (m_rvalid) m_rdata = mem.exists(t_addr) ? mem[t_addr] : ~t_addr;
            else          m_rdata = $urandom;
            #1;
            gd = (phase == 0) && dpend && (!ipend || starve < SL);
            gi = (phase == 0) && ipend && !gd;
            checks++;
            if (i_gnt !== gi || d_gnt !== gd) begin
                errors++; $display("FAIL rnd_gnt c%0d: i_gnt=%b d_gnt=%b want %b %b", c, i_gnt, d_gnt, gi, gd);
            end
            checks++;
            if (busy !== (phase != 0) || m_req !== (phase == 1) || err !== 1'b0) begin
                errors++; $display("FAIL rnd_state c%0d: busy=%b m_req=%b err=%b phase=%0d", c, busy, m_req, err, phase);
            end
            if (phase == 1) begin
                checks++;
                if (m_we !== t_we || m_addr !== t_addr || (t_we && m_wdata !== t_wdata)) begin
                    errors++; $display("FAIL rnd_payload c%0d: we=%b addr=%h wdata=%h want %b %h %h",
                                       c, m_we, m_addr, m_wdata, t_we, t_addr, t_wdata);
                end
            end
            checks++;
            if (i_rvalid !== exp_irv || d_rvalid !== exp_drv || i_rdata !== exp_ird || d_rdata !== exp_drd) begin
                errors++; $display("FAIL rnd_resp c%0d: rv=%b%b rdata=%h/%h want %b%b %h/%h",
                                   c, i_rvalid, d_rvalid, i_rdata, d_rdata, exp_irv, exp_drv, exp_ird, exp_drd);
            end
            exp_irv = 0; exp_drv = 0;
            if (gd || gi) begin
                own_d = gd; t_we = gd && d_we;
                t_addr = gd ? d_addr : i_addr;
                t_wdata = d_wdata;
                starve = (gd && ipend) ? ((starve + 1 > SL) ? SL : starve + 1) : 0;
                if (gd) dpend = 0; else ipend = 0;
                phase = 1;
            end else if (phase == 1 && m_gnt) begin
                if (t_we) begin
                    mem[t_addr] = t_wdata; exp_drv = 1; phase = 0;
                end else begin
                    phase = 2;
                end
            end else if (phase == 2 && m_rvalid) begin
                if (own_d) begin exp_drv = 1; exp_drd = m_rdata; end
                else       begin exp_irv = 1; exp_ird = m_rdata; end
                phase = 0;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        test_reset();
        test_single_load();
        test_store_stall();
        test_contention();
        test_reset_in_wait();
        test_stray();
        test_random(2000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
